// File: rtl/bram1_pkg.sv
// Shared helpers for the BRAM1 server adapter: read latency and credit counter width.
package bram1_pkg;

  function automatic int lat_f(input int pipelined);
    return 1 + pipelined;
  endfunction

  // Credit counter must represent 0..depth inclusive.
  function automatic int credit_w_f(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/bram1.sv
// Single-port block RAM model with optional output register (read latency 1 or 2).
module bram1 #(
  parameter int PIPELINED  = 0,
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1
) (
  input  logic                  CLK,
  input  logic                  EN,
  input  logic                  WE,
  input  logic [ADDR_WIDTH-1:0] ADDR,
  input  logic [DATA_WIDTH-1:0] DI,
  output logic [DATA_WIDTH-1:0] DO
);
  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_q, rd2_q;

  always_ff @(posedge CLK) begin
    if (EN) begin
      if (WE) mem_q[ADDR] <= DI;
      else    rd_q        <= mem_q[ADDR];
    end
    rd2_q <= rd_q;
  end

  assign DO = (PIPELINED != 0) ? rd2_q : rd_q;

endmodule

// File: rtl/bram1_rsp_fifo.sv
// Response buffer: circular FIFO of read data, registered head, no bypass path.
module bram1_rsp_fifo import bram1_pkg::*; #(
  parameter int DATA_WIDTH = 1,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = credit_w_f(RSP_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];
  logic [PW-1:0]         wr_q, rd_q;
  logic [CW-1:0]         cnt_q;

  // Pointers wrap at RSP_DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] inc_f(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= push_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= inc_f(wr_q);
      if (pop_i)  rd_q <= inc_f(rd_q);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign valid_o = (cnt_q != '0);
  assign data_o  = mem_q[rd_q];

endmodule

// File: rtl/bram1_server_adapter.sv
// Request/response wrapper around a single-port BRAM: credit-based flow control
// guarantees every issued read has a slot in the response buffer.
module bram1_server_adapter import bram1_pkg::*; #(
  parameter int PIPELINED  = 0,
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_di,
  input  logic [DATA_WIDTH-1:0] bram_do
);
  localparam int LAT = lat_f(PIPELINED);
  localparam int CW  = credit_w_f(RSP_DEPTH);

  logic [CW-1:0]  credit_q, credit_d;
  logic [LAT-1:0] vld_q, vld_d;
  logic           acc, rd_acc, pop, fifo_valid;

  // Credits cover both buffered entries and reads still inside the BRAM pipe.
  assign req_ready = !RST && (credit_q < CW'(RSP_DEPTH));
  assign acc       = req_valid && req_ready;
  assign rd_acc    = acc && !req_we;

  assign bram_en   = acc;
  assign bram_we   = acc && req_we;
  assign bram_addr = req_addr;
  assign bram_di   = req_data;

  assign rsp_valid = fifo_valid && !RST;
  assign pop       = rsp_valid && rsp_ready;

  always_comb begin
    vld_d    = LAT'({vld_q, rd_acc});
    credit_d = credit_q + CW'(rd_acc) - CW'(pop);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_q    <= '0;
      credit_q <= '0;
    end else begin
      vld_q    <= vld_d;
      credit_q <= credit_d;
    end
  end

  bram1_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .RSP_DEPTH  (RSP_DEPTH)
  ) u_fifo (
    .clk_i       (CLK),
    .rst_i       (RST),
    .push_i      (vld_q[LAT-1]),
    .push_data_i (bram_do),
    .pop_i       (pop),
    .valid_o     (fifo_valid),
    .data_o      (rsp_data)
  );

endmodule

// File: tb/tb_bram1_server_adapter.sv
// Scoreboard bench: instance 0 uses PIPELINED=0, instance 1 uses PIPELINED=1, each on its own BRAM1.
module tb_bram1_server_adapter;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       req_valid [2];
  logic       req_ready [2];
  logic       req_we    [2];
  logic [3:0] req_addr  [2];
  logic [7:0] req_data  [2];
  logic       rsp_valid [2];
  logic       rsp_ready [2];
  logic [7:0] rsp_data  [2];
  logic       bram_en   [2];
  logic       bram_we   [2];
  logic [3:0] bram_addr [2];
  logic [7:0] bram_di   [2];
  logic [7:0] bram_do   [2];

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 2; g++) begin : g_inst
    bram1_server_adapter #(.PIPELINED(g), .ADDR_WIDTH(4), .DATA_WIDTH(8), .RSP_DEPTH(4)) u_dut (
      .CLK(CLK), .RST(RST),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_we(req_we[g]),
      .req_addr(req_addr[g]), .req_data(req_data[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_data(rsp_data[g]),
      .bram_en(bram_en[g]), .bram_we(bram_we[g]), .bram_addr(bram_addr[g]),
      .bram_di(bram_di[g]), .bram_do(bram_do[g]));
    bram1 #(.PIPELINED(g), .ADDR_WIDTH(4), .DATA_WIDTH(8)) u_bram (
      .CLK(CLK), .EN(bram_en[g]), .WE(bram_we[g]), .ADDR(bram_addr[g]),
      .DI(bram_di[g]), .DO(bram_do[g]));
  end

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [7:0] model [2][16];
  logic [7:0] exp0 [$];
  logic [7:0] exp1 [$];
  int         pops1 [$];
  logic       hold_v [2];
  logic [7:0] hold_d [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int i, input logic [7:0] d);
    if (i == 0) exp0.push_back(d);
    else        exp1.push_back(d);
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? exp0.size() : exp1.size();
  endfunction

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Monitor: pops the scoreboard on every response handshake, checks head stability under backpressure.
  initial begin
    hold_v[0] = 1'b0;
    hold_v[1] = 1'b0;
    forever begin
      @(negedge CLK);
      for (int i = 0; i < 2; i++) begin
        if (hold_v[i] && rsp_valid[i]) chk("rsp_hold", rsp_data[i], hold_d[i]);
        if (rsp_valid[i] && rsp_ready[i]) begin
          if (qsize(i) == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_rsp inst=%0d actual=%0h expected=none", i, rsp_data[i]);
          end else begin
            logic [7:0] e;
            e = (i == 0) ? exp0.pop_front() : exp1.pop_front();
            chk($sformatf("rsp_data%0d", i), rsp_data[i], e);
            if (i == 1) pops1.push_back(cyc);
          end
        end
        hold_v[i] = rsp_valid[i] && !rsp_ready[i];
        hold_d[i] = rsp_data[i];
      end
    end
  end

  task automatic do_req(input int i, input logic we, input logic [3:0] a, input logic [7:0] d,
                        output int waits);
    req_valid[i] = 1'b1; req_we[i] = we; req_addr[i] = a; req_data[i] = d;
    waits = 0;
    forever begin
      @(negedge CLK);
      if (req_ready[i]) break;
      chk("bram_en_idle", bram_en[i], 0);
      waits++;
      if (waits > 50) begin
        checks++;
        errors++;
        $display("FAIL req_timeout inst=%0d actual=stalled expected=accept", i);
        break;
      end
      @(posedge CLK); #1;
    end
    if (req_ready[i]) begin
      chk("bram_en", bram_en[i], 1);
      chk("bram_we", bram_we[i], we);
      chk("bram_addr", bram_addr[i], a);
      if (we) begin
        chk("bram_di", bram_di[i], d);
        model[i][a] = d;
      end else push_exp(i, model[i][a]);
    end
    @(posedge CLK); #1;
  endtask

  // Holds a read request for n cycles with a changing address, counting accepts.
  task automatic stream_reads(input int i, input int n, input int base, output int cnt);
    cnt = 0;
    req_valid[i] = 1'b1; req_we[i] = 1'b0;
    for (int j = 0; j < n; j++) begin
      req_addr[i] = 4'((base + j) % 16);
      @(negedge CLK);
      if (req_ready[i]) begin
        cnt++;
        push_exp(i, model[i][req_addr[i]]);
      end
      @(posedge CLK); #1;
    end
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, n;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b1; req_we[i] = 1'b0; req_addr[i] = '0; req_data[i] = '0;
      rsp_ready[i] = 1'b1;
    end
    // Reset state, with a request held to show it is not accepted.
    wait_cycles(2);
    @(negedge CLK);
    for (int i = 0; i < 2; i++) begin
      chk("rst_req_ready", req_ready[i], 0);
      chk("rst_rsp_valid", rsp_valid[i], 0);
      chk("rst_bram_en", bram_en[i], 0);
      chk("rst_bram_we", bram_we[i], 0);
    end
    @(posedge CLK); #1;
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    RST = 1'b0;

    // Preload both memories.
    for (int a = 0; a < 16; a++) begin
      do_req(0, 1'b1, 4'(a), 8'(8'h40 + a), w);
      do_req(1, 1'b1, 4'(a), 8'(a * 3), w);
    end
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    wait_cycles(2);

    // Write then read, PIPELINED=0: response two cycles after the read accept.
    do_req(0, 1'b1, 4'd3, 8'hA5, w);
    do_req(0, 1'b0, 4'd3, 8'h00, w);
    req_valid[0] = 1'b0;
    @(negedge CLK);
    chk("lat_cycle1", rsp_valid[0], 0);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("lat_cycle2", rsp_valid[0], 1);
    chk("lat_data", rsp_data[0], 8'hA5);
    wait_cycles(3);

    // PIPELINED=1 back-to-back reads: no stalls, one response per cycle in order.
    pops1.delete();
    for (int k = 0; k < 8; k++) begin
      do_req(1, 1'b0, 4'(k), 8'h00, w);
      chk("b2b_stall", w, 0);
    end
    req_valid[1] = 1'b0;
    wait_cycles(6);
    chk("b2b_count", pops1.size(), 8);
    for (int k = 1; k < pops1.size(); k++) chk("b2b_spacing", pops1[k] - pops1[k-1], 1);

    // Backpressure: exactly RSP_DEPTH accepts, then one more per popped response.
    rsp_ready[0] = 1'b0;
    stream_reads(0, 10, 0, n);
    chk("bp_accepts", n, 4);
    req_valid[0] = 1'b1;
    @(negedge CLK);
    chk("bp_ready_low", req_ready[0], 0);
    @(posedge CLK); #1;
    rsp_ready[0] = 1'b1;
    @(posedge CLK); #1;
    rsp_ready[0] = 1'b0;
    stream_reads(0, 6, 10, n);
    chk("bp_one_more", n, 1);
    rsp_ready[0] = 1'b1;
    wait_cycles(8);
    chk("bp_drained", exp0.size(), 0);

    // Interleaved write/read at the same address on both latencies.
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 5; k++) begin
        do_req(i, 1'b1, 4'd9, 8'(k * 17 + 1 + i), w);
        do_req(i, 1'b0, 4'd9, 8'h00, w);
      end
      req_valid[i] = 1'b0;
    end
    wait_cycles(6);

    // Reset with one response buffered and two reads in flight (PIPELINED=1).
    rsp_ready[1] = 1'b0;
    do_req(1, 1'b0, 4'd1, 8'h00, w);
    do_req(1, 1'b0, 4'd2, 8'h00, w);
    do_req(1, 1'b0, 4'd4, 8'h00, w);
    req_valid[1] = 1'b0;
    RST = 1'b1;
    exp1.delete();
    @(negedge CLK);
    chk("mid_rst_rsp_valid", rsp_valid[1], 0);
    chk("mid_rst_req_ready", req_ready[1], 0);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("mid_rst_rsp_valid2", rsp_valid[1], 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    rsp_ready[1] = 1'b1;
    @(negedge CLK);
    chk("post_rst_req_ready", req_ready[1], 1);
    for (int k = 0; k < 5; k++) begin
      chk("post_rst_rsp_valid", rsp_valid[1], 0);
      @(negedge CLK);
    end
    @(posedge CLK); #1;
    // Credit count restarted from zero: a full RSP_DEPTH of reads fits again.
    rsp_ready[1] = 1'b0;
    stream_reads(1, 8, 5, n);
    chk("post_rst_credits", n, 4);
    rsp_ready[1] = 1'b1;
    wait_cycles(8);

    chk("final_q0_empty", exp0.size(), 0);
    chk("final_q1_empty", exp1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
